// File: rtl/rom_cheb_seq.sv
// Writable multi-table Chebyshev coefficient store with a
// streaming read sequencer (valid/ready, wrap, loop, abort).
module rom_cheb_seq #(
  parameter  int DATA_W = 16,
  parameter  int ADDR_W = 3,
  parameter  int N_CH   = 4,
  localparam int DEPTH  = 2 ** ADDR_W,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              c_clk,
  input  logic              c_rst,
  input  logic              c_wr_en,
  input  logic [CH_W-1:0]   i_wr_ch,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              c_start,
  input  logic [CH_W-1:0]   i_ch,
  input  logic [ADDR_W-1:0] i_first,
  input  logic [ADDR_W:0]   i_count,
  input  logic              c_loop,
  input  logic              c_abort,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_last,
  output logic              o_busy,
  output logic              o_err
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  localparam logic [CH_W:0]   NCH = (CH_W + 1)'(N_CH);
  localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] TWO = (ADDR_W + 1)'(2);
  localparam logic [ADDR_W:0] ZER = '0;

  state_t state_q, state_d;

  logic [CH_W-1:0]   ch_q, ch_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              loop_q, loop_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem_q [N_CH][DEPTH];

  logic              idle;
  logic              wr_ch_ok;
  logic              st_ch_ok;
  logic              start_ok;
  logic              wr_ok;
  logic              xfer;
  logic [CH_W-1:0]   rd_ch;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  assign idle     = (state_q == S_IDLE);
  assign wr_ch_ok = ({1'b0, i_wr_ch} < NCH);
  assign st_ch_ok = ({1'b0, i_ch} < NCH);
  assign start_ok = idle && c_start && st_ch_ok
                    && (i_count != ZER);
  assign wr_ok    = c_wr_en && idle && wr_ch_ok
                    && !start_ok;
  assign xfer     = valid_q && i_ready;

  // Single read port: start word in IDLE,
  // wrap to first at end of pass, else next.
  always_comb begin
    rd_ch   = ch_q;
    rd_addr = addr_q + 1'b1;
    if (idle) begin
      rd_ch   = i_ch;
      rd_addr = i_first;
    end else if (last_q) begin
      rd_addr = first_q;
    end
  end

  assign rd_data = mem_q[rd_ch][rd_addr];

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    first_d = first_q;
    addr_d  = addr_q;
    count_d = count_q;
    rem_d   = rem_q;
    loop_d  = loop_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    err_d   = (c_wr_en && !wr_ok)
              || (idle && c_start && !start_ok);
    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_RUN;
          ch_d    = i_ch;
          first_d = i_first;
          count_d = i_count;
          loop_d  = c_loop;
          addr_d  = i_first;
          rem_d   = i_count;
          data_d  = rd_data;
          valid_d = 1'b1;
          last_d  = (i_count == ONE);
        end
      end
      S_RUN: begin
        if (c_abort) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = S_IDLE;
        end else if (xfer) begin
          if (last_q && loop_q) begin
            addr_d = first_q;
            rem_d  = count_q;
            data_d = rd_data;
            last_d = (count_q == ONE);
          end else if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            addr_d = rd_addr;
            rem_d  = rem_q - ONE;
            data_d = rd_data;
            last_d = (rem_q == TWO);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (c_rst) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      first_q <= '0;
      addr_q  <= '0;
      count_q <= '0;
      rem_q   <= '0;
      loop_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      first_q <= first_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      loop_q  <= loop_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // Storage survives reset by design.
  always_ff @(posedge c_clk) begin
    if (wr_ok) begin
      mem_q[i_wr_ch][i_wr_addr] <= i_wr_data;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_last  = last_q;
  assign o_busy  = (state_q == S_RUN);
  assign o_err   = err_q;

endmodule

// File: tb/tb_rom_cheb_seq.sv
// Bench for rom_cheb_seq: directed scenarios plus random
// writes/streams against a table-and-queue reference model.
module tb_rom_cheb_seq;

  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int NCH   = 3;
  localparam int CW    = 2;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          c_rst;
  logic          c_wr_en;
  logic [CW-1:0] i_wr_ch;
  logic [AW-1:0] i_wr_addr;
  logic [DW-1:0] i_wr_data;
  logic          c_start;
  logic [CW-1:0] i_ch;
  logic [AW-1:0] i_first;
  logic [AW:0]   i_count;
  logic          c_loop;
  logic          c_abort;
  logic          i_ready;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          o_last;
  logic          o_busy;
  logic          o_err;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model [NCH][DEPTH];

  always #5 clk = ~clk;

  rom_cheb_seq #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .N_CH  (NCH)
  ) dut (
    .c_clk    (clk),
    .c_rst    (c_rst),
    .c_wr_en  (c_wr_en),
    .i_wr_ch  (i_wr_ch),
    .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data),
    .c_start  (c_start),
    .i_ch     (i_ch),
    .i_first  (i_first),
    .i_count  (i_count),
    .c_loop   (c_loop),
    .c_abort  (c_abort),
    .i_ready  (i_ready),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .o_last   (o_last),
    .o_busy   (o_busy),
    .o_err    (o_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int a,
                    input logic [DW-1:0] d);
    c_wr_en   = 1'b1;
    i_wr_ch   = CW'(ch);
    i_wr_addr = AW'(a);
    i_wr_data = d;
    tick();
    c_wr_en = 1'b0;
    chk("wr_err", {31'b0, o_err}, 0);
    model[ch][a] = d;
  endtask

  function automatic bit rdy_of(int mode, int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return !(cyc >= 2 && cyc <= 4);
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  // Non-loop stream; mode 0 = ready held high,
  // 1 = ready low in cycles 2-4, 2 = random ready.
  task automatic stream(input int ch, input int first,
                        input int count, input int mode);
    logic [DW-1:0] exp[$];
    int idx;
    int cyc;
    bit r;
    exp = {};
    for (int k = 0; k < count; k++)
      exp.push_back(model[ch][(first + k) % DEPTH]);
    i_ch    = CW'(ch);
    i_first = AW'(first);
    i_count = (AW + 1)'(count);
    c_loop  = 1'b0;
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    cyc = 1;
    idx = 0;
    while (idx < count && cyc < 400) begin
      r = rdy_of(mode, cyc);
      i_ready = r;
      chk("valid", {31'b0, o_valid}, 1);
      chk("busy", {31'b0, o_busy}, 1);
      chk("data", {16'b0, o_data}, {16'b0, exp[idx]});
      if (r) begin
        chk("last", {31'b0, o_last},
            (idx == count - 1) ? 1 : 0);
        idx++;
      end
      tick();
      cyc++;
    end
    i_ready = 1'b0;
    chk("timeout", idx, count);
    chk("end_valid", {31'b0, o_valid}, 0);
    chk("end_busy", {31'b0, o_busy}, 0);
    if (mode == 0) chk("duration", cyc, count + 1);
  endtask

  initial begin
    logic [DW-1:0] tbl [8];
    tbl = '{16'h7FFF, 16'hB000, 16'hE400, 16'h72FF,
            16'h8C40, 16'h1DAF, 16'h4EA3, 16'h8003};
    c_rst     = 1'b1;
    c_wr_en   = 1'b0;
    i_wr_ch   = '0;
    i_wr_addr = '0;
    i_wr_data = '0;
    c_start   = 1'b0;
    i_ch      = '0;
    i_first   = '0;
    i_count   = '0;
    c_loop    = 1'b0;
    c_abort   = 1'b0;
    i_ready   = 1'b0;
    tick();
    tick();
    chk("rst_data", {16'b0, o_data}, 0);
    chk("rst_valid", {31'b0, o_valid}, 0);
    chk("rst_last", {31'b0, o_last}, 0);
    chk("rst_busy", {31'b0, o_busy}, 0);
    chk("rst_err", {31'b0, o_err}, 0);
    c_rst = 1'b0;

    for (int a = 0; a < 8; a++) wr(0, a, tbl[a]);

    stream(0, 0, 8, 0);
    stream(0, 6, 4, 0);
    stream(0, 0, 8, 1);

    // Loop pass B000,E400 repeating; abort with a transfer.
    i_ch    = 2'd0;
    i_first = 3'd1;
    i_count = 4'd2;
    c_loop  = 1'b1;
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    c_loop  = 1'b0;
    for (int k = 0; k < 6; k++) begin
      i_ready = 1'b1;
      chk("lp_valid", {31'b0, o_valid}, 1);
      chk("lp_data", {16'b0, o_data},
          {16'b0, model[0][1 + (k % 2)]});
      chk("lp_last", {31'b0, o_last}, (k % 2 == 1) ? 1 : 0);
      if (k == 5) c_abort = 1'b1;
      tick();
    end
    c_abort = 1'b0;
    i_ready = 1'b0;
    chk("ab_valid", {31'b0, o_valid}, 0);
    chk("ab_busy", {31'b0, o_busy}, 0);
    chk("ab_last", {31'b0, o_last}, 0);

    // Write while busy is dropped and flagged.
    i_ch    = 2'd0;
    i_first = 3'd0;
    i_count = 4'd8;
    c_start = 1'b1;
    tick();
    c_start   = 1'b0;
    c_wr_en   = 1'b1;
    i_wr_ch   = 2'd0;
    i_wr_addr = 3'd3;
    i_wr_data = 16'h1234;
    tick();
    c_wr_en = 1'b0;
    chk("busy_wr_err", {31'b0, o_err}, 1);
    tick();
    chk("busy_wr_err_end", {31'b0, o_err}, 0);
    c_abort = 1'b1;
    tick();
    c_abort = 1'b0;
    chk("busy_wr_idle", {31'b0, o_busy}, 0);
    stream(0, 3, 1, 0);

    // Bad table select and zero count.
    i_ch    = 2'd3;
    i_count = 4'd4;
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    chk("badch_err", {31'b0, o_err}, 1);
    chk("badch_valid", {31'b0, o_valid}, 0);
    chk("badch_busy", {31'b0, o_busy}, 0);
    tick();
    chk("badch_err_end", {31'b0, o_err}, 0);
    i_ch    = 2'd0;
    i_count = 4'd0;
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    chk("cnt0_err", {31'b0, o_err}, 1);
    chk("cnt0_valid", {31'b0, o_valid}, 0);
    c_wr_en = 1'b1;
    i_wr_ch = 2'd3;
    tick();
    c_wr_en = 1'b0;
    chk("badwr_err", {31'b0, o_err}, 1);

    // Write coincident with an accepted start is dropped.
    i_ch      = 2'd0;
    i_first   = 3'd0;
    i_count   = 4'd1;
    c_start   = 1'b1;
    c_wr_en   = 1'b1;
    i_wr_ch   = 2'd0;
    i_wr_addr = 3'd0;
    i_wr_data = 16'h0000;
    tick();
    c_start = 1'b0;
    c_wr_en = 1'b0;
    chk("cowr_err", {31'b0, o_err}, 1);
    chk("cowr_valid", {31'b0, o_valid}, 1);
    chk("cowr_data", {16'b0, o_data}, {16'b0, model[0][0]});
    chk("cowr_last", {31'b0, o_last}, 1);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk("cowr_end", {31'b0, o_valid}, 0);
    stream(0, 0, 1, 0);

    // Reset mid-stream keeps storage.
    i_ready = 1'b1;
    i_first = 3'd0;
    i_count = 4'd8;
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    tick();
    tick();
    c_rst = 1'b1;
    tick();
    c_rst   = 1'b0;
    i_ready = 1'b0;
    chk("mrst_data", {16'b0, o_data}, 0);
    chk("mrst_valid", {31'b0, o_valid}, 0);
    chk("mrst_last", {31'b0, o_last}, 0);
    chk("mrst_busy", {31'b0, o_busy}, 0);
    chk("mrst_err", {31'b0, o_err}, 0);
    stream(0, 0, 8, 0);

    // Write then start the next cycle.
    wr(1, 2, 16'hA5A5);
    stream(1, 2, 1, 0);

    for (int c = 1; c < NCH; c++)
      for (int a = 0; a < DEPTH; a++)
        wr(c, a, DW'($urandom));

    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        wr($urandom_range(0, NCH - 1),
           $urandom_range(0, DEPTH - 1), DW'($urandom));
      end else begin
        stream($urandom_range(0, NCH - 1),
               $urandom_range(0, DEPTH - 1),
               $urandom_range(1, 12),
               ($urandom_range(0, 3) == 0) ? 0 : 2);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_cheb_seq.md
# rom_cheb_seq

Parametrised, writable Chebyshev coefficient store with a streaming read sequencer. It holds `N_CH` tables of `DEPTH` coefficients T(i)(x_k), one table per sample point x_k. On command it streams a run of coefficients from one table over a valid/ready handshake, with address wrap-around and an optional loop mode. It sits between the coefficient loader and the filter MAC datapath. It replaces the fixed single-table, combinational, tristated per-x coefficient ROMs.

## Interface
Parameters:
- `DATA_W`, 16, coefficient width.
- `ADDR_W`, 3, table address width; `DEPTH = 2**ADDR_W`.
- `N_CH`, 4, number of tables (x sample points); `CH_W = max(1, clog2(N_CH))`.

Ports:
- `c_clk`  in  1  sole clock; all logic on the rising edge.
- `c_rst`  in  1  reset; synchronous, active-high.
- `c_wr_en`  in  1  write strobe.
- `i_wr_ch`  in  CH_W  write table select.
- `i_wr_addr`  in  ADDR_W  write address.
- `i_wr_data`  in  DATA_W  write data.
- `c_start`  in  1  start a stream (single-cycle pulse, sampled only in IDLE).
- `i_ch`  in  CH_W  stream table select.
- `i_first`  in  ADDR_W  first address of the run.
- `i_count`  in  ADDR_W+1  words per pass; 0 is illegal.
- `c_loop`  in  1  latched at start; repeat the run until aborted.
- `c_abort`  in  1  terminate the stream.
- `i_ready`  in  1  consumer accepts `o_data`.
- `o_data`  out  DATA_W  coefficient.
- `o_valid`  out  1  `o_data` valid.
- `o_last`  out  1  final word of the current pass; qualified by `o_valid`.
- `o_busy`  out  1  state is RUN.
- `o_err`  out  1  one-cycle pulse on a rejected command.

## Operation
- Storage: `N_CH` x `DEPTH` x `DATA_W` registers. Reset does not clear storage; contents are undefined until written.
- Write: when `c_wr_en` is high, state is IDLE and `i_wr_ch < N_CH`, `mem[i_wr_ch][i_wr_addr] <= i_wr_data` at the edge. Otherwise the write is dropped and `o_err` pulses the next cycle. A write in the same cycle as an accepted `c_start` is also rejected.
- FSM states IDLE and RUN.
  - IDLE -> RUN on `c_start` with `i_ch < N_CH` and `i_count != 0`. At that edge the block latches ch, first, count and loop, and loads the output register with `mem[i_ch][i_first]`, `o_valid <= 1`, `o_last <= (i_count == 1)`.
  - A bad `i_ch` or a zero count leaves the FSM in IDLE and pulses `o_err`.
  - `c_start` in RUN is ignored, with no error.
- RUN:
  - An output transfer occurs when `o_valid && i_ready`. On a transfer, if words remain in the pass, load the next word: address = (previous address + 1) mod DEPTH, because address arithmetic is ADDR_W-bit and wraps naturally. Set `o_last` when the remaining count reaches 1.
  - Transfer of the `o_last` word with loop clear: `o_valid <= 0`, go to IDLE.
  - Transfer of the `o_last` word with loop set: reload `mem[ch][first]`, reset the pass counter, and stay in RUN with no bubble.
  - With no transfer, `o_data`, `o_valid` and `o_last` hold.
- `c_abort` in RUN takes priority over a transfer at the same edge: `o_valid <= 0`, `o_last <= 0`, go to IDLE. `c_abort` in IDLE has no effect.
- `i_count > DEPTH` is legal: addresses keep wrapping, so table words repeat.
- `o_data` is registered, with no tristate. It holds its last value when `o_valid` is low.

## Timing
- Reset values: `o_data = 0`, `o_valid = 0`, `o_last = 0`, `o_busy = 0`, `o_err = 0`, state IDLE, counters 0.
- `c_rst` mid-stream returns the block to reset values at the next edge and discards the stream. Storage is retained.
- Start latency: with `c_start` high in cycle 0, the first word is valid in cycle 1.
- Throughput: one word per cycle while `i_ready` is held high. There are no bubbles between loop passes.
- Stream duration with `i_ready` held high and loop clear: `o_valid` is high for exactly `count` cycles (cycles 1..count). `o_busy` drops in cycle count+1, and a new `c_start` is accepted in that cycle.
- Write latency: one cycle. A write followed by a start in the next cycle streams the new value.
- `o_err` is high for exactly the cycle after the offending command.

## Test plan
- Load ch0 with 7FFF, B000, E400, 72FF, 8C40, 1DAF, 4EA3, 8003 at addresses 0-7. Then start ch0, first=0, count=8, `i_ready`=1 -> those 8 words on cycles 1-8, `o_last` only with 8003, `o_busy` low in cycle 9.
- Wrap-around: ch0, first=6, count=4 -> 4EA3, 8003, 7FFF, B000, with `o_last` on B000.
- Backpressure: drop `i_ready` in cycles 2-4 of the first scenario -> `o_data` holds B000 and `o_valid` stays high. The remaining sequence continues intact with no loss or duplication.
- Loop and abort: ch0, first=1, count=2, loop=1 -> B000, E400, B000, E400, and so on, with `o_last` on each E400. Assert `c_abort` together with an accepted transfer -> `o_valid` is 0 in the next cycle and the state is IDLE.
- Errors: write while `o_busy` -> `o_err` pulse, and a later read of that address returns the old value. Start with `i_ch = N_CH` or count=0 -> `o_err` pulse, `o_valid` stays 0.
- Reset mid-stream: assert `c_rst` in cycle 3 of a stream -> all outputs 0 next cycle. A following start re-streams the retained contents correctly.
